// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: in-order capture of committed GRF/DM write events with a
// valid/ready read port and overflow accounting for dropped events.
module wb_trace_fifo #(
  parameter int DEPTH       = 16,
  parameter int DROP_CNT_W  = 16,
  parameter bit FILTER_ZERO = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic                    wr_kind,
  input  logic [31:0]             wr_pc,
  input  logic [31:0]             wr_addr,
  input  logic [31:0]             wr_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    rd_kind,
  output logic [31:0]             rd_pc,
  output logic [31:0]             rd_addr,
  output logic [31:0]             rd_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    overflow,
  output logic [DROP_CNT_W-1:0]   dropped
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  entry_t         mem [DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  entry_t         new_entry;
  entry_t         head_entry;
  logic           filtered;
  logic           push;
  logic           pop;
  logic           drop;

  assign full     = (count == CW'(DEPTH));
  assign rd_valid = (count != '0);

  // Classify this cycle's event: filtered, push, drop; and build the entry.
  always_comb begin
    filtered  = FILTER_ZERO && wr_en && !wr_kind && (wr_addr[4:0] == 5'd0);
    pop       = rd_valid && rd_ready;
    push      = wr_en && !filtered && (!full || pop);
    drop      = wr_en && !filtered && full && !pop;
    new_entry.kind = wr_kind;
    new_entry.pc   = wr_pc;
    new_entry.addr = wr_kind ? wr_addr : {27'b0, wr_addr[4:0]};
    new_entry.data = wr_data;
  end

  // Storage array write at the tail.
  // NOTE: the array is deliberately not reset; count gates every read, so
  // stale contents are never visible and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (!reset && push) mem[tail] <= new_entry;
  end

  // Pointers, occupancy and overflow bookkeeping.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      dropped  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (dropped != '1) dropped <= dropped + 1'b1;
      end
    end
  end

  // Head entry presented combinationally; zeroed whenever the FIFO is empty.
  always_comb begin
    head_entry = rd_valid ? mem[head] : '0;
    rd_kind    = head_entry.kind;
    rd_pc      = head_entry.pc;
    rd_addr    = head_entry.addr;
    rd_data    = head_entry.data;
  end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed self-checking bench for wb_trace_fifo.
module tb_wb_trace_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic        wr_kind;
  logic [31:0] wr_pc;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        rd_ready;

  logic        rd_valid, rd_kind, full, overflow;
  logic [31:0] rd_pc, rd_addr, rd_data;
  logic [4:0]  count;
  logic [15:0] dropped;

  logic        nf_valid, nf_kind, nf_full, nf_overflow;
  logic [31:0] nf_pc, nf_addr, nf_data;
  logic [4:0]  nf_count;
  logic [15:0] nf_dropped;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_trace_fifo #(.DEPTH(16), .DROP_CNT_W(16), .FILTER_ZERO(1'b1)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_kind(wr_kind),
    .wr_pc(wr_pc), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_kind(rd_kind),
    .rd_pc(rd_pc), .rd_addr(rd_addr), .rd_data(rd_data),
    .count(count), .full(full), .overflow(overflow), .dropped(dropped)
  );

  wb_trace_fifo #(.DEPTH(16), .DROP_CNT_W(16), .FILTER_ZERO(1'b0)) dut_nf (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_kind(wr_kind),
    .wr_pc(wr_pc), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(nf_valid), .rd_ready(rd_ready), .rd_kind(nf_kind),
    .rd_pc(nf_pc), .rd_addr(nf_addr), .rd_data(nf_data),
    .count(nf_count), .full(nf_full), .overflow(nf_overflow), .dropped(nf_dropped)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic en, input logic kind, input logic [31:0] pc,
                        input logic [31:0] addr, input logic [31:0] data);
    wr_en   = en;
    wr_kind = kind;
    wr_pc   = pc;
    wr_addr = addr;
    wr_data = data;
  endtask

  initial begin
    reset    = 1'b1;
    rd_ready = 1'b0;
    set_wr(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_valid",    32'(rd_valid), 32'd0);
    check("rst_count",    32'(count),    32'd0);
    check("rst_full",     32'(full),     32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_dropped",  32'(dropped),  32'd0);
    check("rst_pc",       rd_pc,         32'd0);
    check("rst_data",     rd_data,       32'd0);

    // Three pushes, consumer stalled
    set_wr(1'b1, 1'b0, 32'h3000, 32'd8, 32'h1);
    tick();
    check("lat_valid", 32'(rd_valid), 32'd1);
    check("lat_pc",    rd_pc,         32'h3000);
    set_wr(1'b1, 1'b1, 32'h3004, 32'h4, 32'hABCD);
    tick();
    set_wr(1'b1, 1'b0, 32'h3008, 32'd9, 32'h2);
    tick();
    set_wr(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    check("p3_count", 32'(count),   32'd3);
    check("p3_pc",    rd_pc,        32'h3000);
    check("p3_kind",  32'(rd_kind), 32'd0);
    check("p3_addr",  rd_addr,      32'd8);
    check("p3_data",  rd_data,      32'h1);
    tick();
    check("stall_pc", rd_pc, 32'h3000);

    // Drain in order
    rd_ready = 1'b1;
    tick();
    check("pop1_pc",   rd_pc,         32'h3004);
    check("pop1_kind", 32'(rd_kind),  32'd1);
    check("pop1_addr", rd_addr,       32'h4);
    check("pop1_data", rd_data,       32'hABCD);
    tick();
    check("pop2_pc",   rd_pc,         32'h3008);
    check("pop2_addr", rd_addr,       32'd9);
    check("pop2_data", rd_data,       32'h2);
    tick();
    check("empty_valid", 32'(rd_valid), 32'd0);
    check("empty_count", 32'(count),    32'd0);
    check("empty_pc",    rd_pc,         32'd0);
    check("empty_addr",  rd_addr,       32'd0);
    check("empty_data",  rd_data,       32'd0);
    rd_ready = 1'b0;

    // Filtering of GRF $0
    set_wr(1'b1, 1'b0, 32'h3100, 32'h0, 32'h55);
    tick();
    check("flt_count",    32'(count),    32'd0);
    check("flt_overflow", 32'(overflow), 32'd0);
    check("flt_dropped",  32'(dropped),  32'd0);
    check("nf_count",     32'(nf_count), 32'd1);
    check("nf_addr",      nf_addr,       32'd0);
    check("nf_data",      nf_data,       32'h55);

    // GRF address truncation
    set_wr(1'b1, 1'b0, 32'h3104, 32'hFFFF_FFE5, 32'h77);
    tick();
    set_wr(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    check("trunc_count", 32'(count), 32'd1);
    check("trunc_addr",  rd_addr,    32'h0000_0005);
    check("trunc_pc",    rd_pc,      32'h3104);
    rd_ready = 1'b1;
    tick();
    check("trunc_drain",  32'(count), 32'd0);
    check("nf_trunc_addr", nf_addr,   32'h0000_0005);
    tick();
    check("nf_drain", 32'(nf_count), 32'd0);
    rd_ready = 1'b0;

    // Overflow: 20 pushes into 16 entries
    for (int i = 0; i < 20; i++) begin
      set_wr(1'b1, 1'b1, 32'h4000 + 32'(4 * i), 32'h100 + 32'(i), 32'(i));
      tick();
    end
    check("ovf_full",     32'(full),     32'd1);
    check("ovf_count",    32'(count),    32'd16);
    check("ovf_overflow", 32'(overflow), 32'd1);
    check("ovf_dropped",  32'(dropped),  32'd4);
    check("ovf_head",     rd_data,       32'd0);

    // Push and pop together while full
    set_wr(1'b1, 1'b1, 32'h5000, 32'h200, 32'h100);
    rd_ready = 1'b1;
    tick();
    set_wr(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    check("pp_full_count",   32'(count),    32'd16);
    check("pp_full_dropped", 32'(dropped),  32'd4);
    check("pp_full_full",    32'(full),     32'd1);
    check("pp_full_head",    rd_data,       32'd1);

    // Drain 11 to leave 5 entries
    for (int i = 0; i < 11; i++) tick();
    rd_ready = 1'b0;
    check("pre_rst_count",    32'(count),    32'd5);
    check("pre_rst_head",     rd_data,       32'd12);
    check("pre_rst_overflow", 32'(overflow), 32'd1);

    // Reset mid-operation with push and pop presented
    reset    = 1'b1;
    rd_ready = 1'b1;
    set_wr(1'b1, 1'b1, 32'h6000, 32'h300, 32'hDEAD);
    tick();
    reset    = 1'b0;
    rd_ready = 1'b0;
    set_wr(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    check("mrst_count",    32'(count),    32'd0);
    check("mrst_valid",    32'(rd_valid), 32'd0);
    check("mrst_overflow", 32'(overflow), 32'd0);
    check("mrst_dropped",  32'(dropped),  32'd0);
    check("mrst_full",     32'(full),     32'd0);
    check("mrst_pc",       rd_pc,         32'd0);
    tick();
    check("mrst_idle_count", 32'(count), 32'd0);

    // Sustained push+pop across pointer wrap
    set_wr(1'b1, 1'b0, 32'h7000, 32'd3, 32'h1000);
    tick();
    rd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_wr(1'b1, 1'b0, 32'h7004 + 32'(4 * i), 32'd3, 32'h1001 + 32'(i));
      check("wrap_data", rd_data, 32'h1000 + 32'(i));
      tick();
      check("wrap_count", 32'(count), 32'd1);
    end
    set_wr(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    rd_ready = 1'b0;
    check("wrap_last_data", rd_data, 32'h1028);
    check("wrap_last_pc",   rd_pc,   32'h7000 + 32'(4 * 40));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_trace_fifo.md
# wb_trace_fifo

Commit-trace buffer on the consumer side of the single-cycle MIPS core's write-back reporting. The core reports each committed register-file (GRF) or data-memory (DM) write as a one-cycle event. This block captures those events in order into a FIFO and hands them out through a valid/ready read port, for a trace printer or comparison checker. It also records events lost to overflow, so a bench can tell a missing write from a dropped one.

## Interface
- DEPTH, 16, FIFO entries; power of two, at least 2
- DROP_CNT_W, 16, width of the dropped-event counter
- FILTER_ZERO, 1, when 1, GRF writes to register 0 are discarded silently
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  reset, synchronous and active-high; clears all state on the edge where it is sampled high
- wr_en  in  1  core commits a write this cycle
- wr_kind  in  1  0 = GRF write, 1 = DM write
- wr_pc  in  32  PC of the committing instruction
- wr_addr  in  32  register number in bits [4:0] for GRF; byte address for DM
- wr_data  in  32  value written
- rd_valid  out  1  head entry is available
- rd_ready  in  1  consumer takes the head entry when rd_valid is also high
- rd_kind  out  1  head entry kind
- rd_pc  out  32  head entry PC
- rd_addr  out  32  head entry address; GRF entries hold {27'b0, wr_addr[4:0]}
- rd_data  out  32  head entry data
- count  out  log2(DEPTH)+1  number of entries held
- full  out  1  count == DEPTH
- overflow  out  1  sticky; set by the first dropped event
- dropped  out  DROP_CNT_W  number of dropped events, saturating

## Operation
- Filtered event: wr_en=1, wr_kind=0, wr_addr[4:0]=0 and FILTER_ZERO=1.
  - Not stored, not counted as dropped, no flag change.
- Push: wr_en=1, the event is not filtered, and one of:
  - full=0, or
  - a pop happens in the same cycle (full=1, rd_valid=1, rd_ready=1).
  - The entry is written at the tail and the tail pointer advances.
- Pop: rd_valid && rd_ready. The head pointer advances.
- Drop: an unfiltered wr_en while full=1 with no pop in the same cycle.
  - The event is discarded and overflow is set to 1.
  - dropped increments, holding at all-ones once saturated.
- count change per cycle: +1 on push only, -1 on pop only, unchanged on push and pop together.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- Ordering is strict FIFO. The bench can tell an entry from its neighbours only by its (pc, kind, addr, data) fields.
- rd_valid = (count != 0).
- rd_kind, rd_pc, rd_addr and rd_data are the head entry when rd_valid=1 and all-zero when rd_valid=0, through a combinational mux from the storage array.
- Reset values: rd_valid=0, count=0, full=0, overflow=0, dropped=0, all rd_* fields 0, pointers 0.
- Reset mid-operation: stored entries are discarded, and any push or pop presented in the reset cycle is ignored. The next cycle behaves as power-up.

## Timing
- Write-to-read latency is 1 cycle: an event pushed at edge N is visible on rd_* after edge N. There is no same-cycle bypass, even into an empty FIFO.
- The consumer may hold rd_ready high permanently, giving a sustained rate of 1 event per cycle in and 1 out.
- rd_* fields stay stable while rd_valid=1 and rd_ready=0.
- count, full, overflow and dropped are registered and update on the same edge as the push, pop or drop that changes them.
- On a simultaneous push and pop at count=1, the popped entry leaves and the pushed entry becomes head on the next cycle; rd_valid stays 1.
- Push and pop together at count=DEPTH: the push is accepted, not dropped, and count stays DEPTH.

## Test plan
- Reset, then 3 pushes in consecutive cycles with rd_ready=0: (pc 0x3000, GRF $8, 0x1), (0x3004, DM addr 0x4, 0xABCD), (0x3008, GRF $9, 0x2) -> count=3. rd_* show the 0x3000 entry. Raising rd_ready pops the three entries in order over 3 cycles, then rd_valid=0 and rd_* read 0.
- GRF write to $0 with FILTER_ZERO=1 -> count, overflow and dropped unchanged. Same write with FILTER_ZERO=0 -> stored with rd_addr=0.
- GRF write with wr_addr=0xFFFF_FFE5 -> rd_addr=0x0000_0005.
- DEPTH=16: 20 pushes with rd_ready=0 -> full=1, count=16, overflow=1, dropped=4. Then a push and pop together -> accepted, count stays 16, dropped stays 4.
- Push one entry, then drive push and pop together every cycle for 40 cycles with incrementing data -> count stays 1 and the data sequence on the read port is exact across pointer wrap.
- Fill 5 entries and assert reset while wr_en=1 and rd_ready=1 -> next cycle count=0, rd_valid=0, overflow=0, dropped=0, with no entry from the reset cycle retained.
